// File: rtl/input_conditioner.sv
// Board-side front end: synchronises and debounces raw buttons and
// generates the downstream active-high reset from board reset and PLL lock.
module input_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD        = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               locked_i,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic               rst_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(RST_HOLD) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD - 1);

  logic [NUM_BTN-1:0] r_btn_m;
  logic [NUM_BTN-1:0] r_btn_s;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [CW-1:0]      r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] w_done;
  logic [NUM_BTN-1:0] w_rise;

  logic               r_lock_m;
  logic               r_lock_s;
  logic [HW-1:0]      r_hold;
  logic               r_rst;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_btn_m <= '0;
      r_btn_s <= '0;
    end else begin
      r_btn_m <= btn_i;
      r_btn_s <= r_btn_m;
    end
  end

  always_comb begin
    w_done = '0;
    w_rise = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_done[i] = (r_btn_s[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
      w_rise[i] = w_done[i] && r_btn_s[i];
    end
  end

  // Any return of btn_s to the accepted level discards all progress.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_level <= '0;
      r_press <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_press <= w_rise;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_btn_s[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (w_done[i]) begin
          r_level[i] <= r_btn_s[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_lock_m <= locked_i;
      r_lock_s <= r_lock_m;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_hold <= '0;
      r_rst  <= 1'b1;
    end else if (!r_lock_s) begin
      r_hold <= '0;
      r_rst  <= 1'b1;
    end else if (r_rst) begin
      if (r_hold == HOLD_MAX) begin
        r_rst <= 1'b0;
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  // Lock loss must reassert reset as soon as the synchronised lock falls.
  assign rst_o   = r_rst | ~r_lock_s;
  assign level_o = r_level;
  assign press_o = r_press;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner
// (DEBOUNCE_CYCLES=8, RST_HOLD=4, NUM_BTN=3).
module tb_input_conditioner;

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic [2:0] btn;
  logic [2:0] level;
  logic [2:0] press;
  logic       rst;

  int n_checks = 0;
  int n_errors = 0;

  input_conditioner #(
    .NUM_BTN(3),
    .DEBOUNCE_CYCLES(8),
    .RST_HOLD(4)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .locked_i(locked),
    .btn_i   (btn),
    .level_o (level),
    .press_o (press),
    .rst_o   (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    locked  = 1'b1;
    btn     = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("por_level", 32'(level), 32'(3'b000));
    check("por_press", 32'(press), 32'(3'b000));
    check("por_rst", 32'(rst), 32'(1'b1));

    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("pu_rst_e%0d", e), 32'(rst), 32'(e < 6));
    end

    btn[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("press_lvl_e%0d", e), 32'(level),
            32'((e >= 10) ? 3'b001 : 3'b000));
      check($sformatf("press_pls_e%0d", e), 32'(press),
            32'((e == 10) ? 3'b001 : 3'b000));
    end

    for (int e = 1; e <= 16; e++) begin
      btn[1] = ((e >= 1 && e <= 5) || (e >= 7 && e <= 11));
      step();
      check($sformatf("bnc_lvl_e%0d", e), 32'(level), 32'(3'b001));
      check($sformatf("bnc_pls_e%0d", e), 32'(press), 32'(3'b000));
    end
    btn[1] = 1'b0;

    btn[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("rel_lvl_e%0d", e), 32'(level),
            32'((e >= 10) ? 3'b000 : 3'b001));
      check($sformatf("rel_pls_e%0d", e), 32'(press), 32'(3'b000));
    end

    btn[2] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      locked = !(e >= 1 && e <= 3);
      step();
      check($sformatf("lck_rst_e%0d", e), 32'(rst),
            32'(e >= 2 && e <= 8));
      check($sformatf("lck_lvl_e%0d", e), 32'(level),
            32'((e >= 10) ? 3'b100 : 3'b000));
      check($sformatf("lck_pls_e%0d", e), 32'(press),
            32'((e == 10) ? 3'b100 : 3'b000));
    end

    btn[2] = 1'b0;
    repeat (12) step();
    check("clr_level", 32'(level), 32'(3'b000));
    check("clr_rst", 32'(rst), 32'(1'b0));

    btn = 3'b111;
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check("mid_level", 32'(level), 32'(3'b000));
    check("mid_press", 32'(press), 32'(3'b000));
    check("mid_rst", 32'(rst), 32'(1'b1));
    step();
    reset_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("mid_lvl_e%0d", e), 32'(level),
            32'((e >= 10) ? 3'b111 : 3'b000));
      check($sformatf("mid_pls_e%0d", e), 32'(press),
            32'((e == 10) ? 3'b111 : 3'b000));
      check($sformatf("mid_rst_e%0d", e), 32'(rst), 32'(e < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
